// File: rtl/oflow_mem_ctrl.sv
// Feature-memory controller: arbitrates feature-record writes and similarity-metric row reads onto dual-port SRAM.
// Optional OFLOW_MEM_CTRL_STATS_EN adds saturating write-stall and read-error counters.
module oflow_mem_ctrl #(
  parameter int DATA_WIDTH_MEM = 284,
  parameter int ADDR_WIDTH     = 8,
  parameter int RAM_DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_N,
  input  logic                      frame_start,
  input  logic                      wr_valid,
  input  logic                      wr_single,
  input  logic [DATA_WIDTH_MEM-1:0] wr_data_0,
  input  logic [DATA_WIDTH_MEM-1:0] wr_data_1,
  output logic                      wr_ready,
  input  logic                      rd_req,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic                      rd_gnt,
  output logic                      rd_valid,
  output logic [DATA_WIDTH_MEM-1:0] rd_data,
  output logic                      rd_err,
  output logic [ADDR_WIDTH:0]       row_count,
`ifdef OFLOW_MEM_CTRL_STATS_EN
  output logic [15:0]               wr_stall_cnt,
  output logic [15:0]               rd_err_cnt,
`endif
  output logic [ADDR_WIDTH-1:0]     mem_address_0,
  output logic [ADDR_WIDTH-1:0]     mem_address_1,
  output logic [DATA_WIDTH_MEM-1:0] mem_data_in_0,
  output logic [DATA_WIDTH_MEM-1:0] mem_data_in_1,
  output logic                      mem_csb_0,
  output logic                      mem_csb_1,
  output logic                      mem_web_0,
  output logic                      mem_web_1,
  output logic                      mem_oeb_0,
  output logic                      mem_oeb_1,
  input  logic [DATA_WIDTH_MEM-1:0] mem_data_out_0
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_ADDR, S_RD_WAIT, S_RD_DATA} state_t;
  typedef enum logic {GNT_WR, GNT_RD} grant_t;

  state_t state, state_nxt;
  grant_t last_grant;
  logic   rd_err_pend;
  logic   full;
  logic   wr_can;
  logic   rd_in_range;
  logic [ADDR_WIDTH+1:0] fill_next;

  assign fill_next   = {1'b0, row_count} + (wr_single ? (ADDR_WIDTH+2)'(1) : (ADDR_WIDTH+2)'(2));
  assign full        = fill_next > (ADDR_WIDTH+2)'(RAM_DEPTH);
  assign rd_in_range = {1'b0, rd_addr} < row_count;
  // Port 1 never reads, so its output enable stays inactive.
  assign mem_oeb_1   = 1'b1;

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    rd_gnt    = 1'b0;
    wr_can    = 1'b0;
    case (state)
      S_IDLE: begin
        if (reset_N && !frame_start) begin
          wr_can = wr_valid && !full;
          if (wr_can && rd_req) begin
            if (last_grant == GNT_RD) wr_ready = 1'b1;
            else                      rd_gnt   = 1'b1;
          end else if (wr_can) begin
            wr_ready = 1'b1;
          end else if (rd_req) begin
            rd_gnt = 1'b1;
          end
        end
        if (wr_ready)    state_nxt = S_WR;
        else if (rd_gnt) state_nxt = S_RD_ADDR;
      end
      S_WR:      state_nxt = S_IDLE;
      S_RD_ADDR: state_nxt = S_RD_WAIT;
      S_RD_WAIT: state_nxt = S_RD_DATA;
      S_RD_DATA: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state         <= S_IDLE;
      last_grant    <= GNT_WR;
      rd_err_pend   <= 1'b0;
      row_count     <= '0;
      rd_valid      <= 1'b0;
      rd_err        <= 1'b0;
      rd_data       <= '0;
      mem_address_0 <= '0;
      mem_address_1 <= '0;
      mem_data_in_0 <= '0;
      mem_data_in_1 <= '0;
      mem_csb_0     <= 1'b1;
      mem_csb_1     <= 1'b1;
      mem_web_0     <= 1'b1;
      mem_web_1     <= 1'b1;
      mem_oeb_0     <= 1'b1;
    end else begin
      state     <= state_nxt;
      mem_csb_0 <= 1'b1;
      mem_csb_1 <= 1'b1;
      mem_web_0 <= 1'b1;
      mem_web_1 <= 1'b1;
      mem_oeb_0 <= 1'b1;
      rd_valid  <= 1'b0;
      rd_err    <= 1'b0;

      if (frame_start)
        row_count <= '0;
      else if (wr_ready)
        row_count <= row_count + (wr_single ? (ADDR_WIDTH+1)'(1) : (ADDR_WIDTH+1)'(2));

      if (wr_ready) begin
        last_grant    <= GNT_WR;
        mem_csb_0     <= 1'b0;
        mem_web_0     <= 1'b0;
        mem_address_0 <= row_count[ADDR_WIDTH-1:0];
        mem_data_in_0 <= wr_data_0;
        if (!wr_single) begin
          mem_csb_1     <= 1'b0;
          mem_web_1     <= 1'b0;
          mem_address_1 <= row_count[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
          mem_data_in_1 <= wr_data_1;
        end
      end

      // Out-of-range reads skip the memory but keep the same three-cycle latency.
      if (rd_gnt) begin
        last_grant  <= GNT_RD;
        rd_err_pend <= !rd_in_range;
        if (rd_in_range) begin
          mem_csb_0     <= 1'b0;
          mem_oeb_0     <= 1'b0;
          mem_address_0 <= rd_addr;
        end
      end

      if (state == S_RD_WAIT) begin
        rd_valid <= 1'b1;
        rd_err   <= rd_err_pend;
        rd_data  <= rd_err_pend ? '0 : mem_data_out_0;
      end
    end
  end

`ifdef OFLOW_MEM_CTRL_STATS_EN
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      wr_stall_cnt <= '0;
      rd_err_cnt   <= '0;
    end else if (frame_start) begin
      wr_stall_cnt <= '0;
      rd_err_cnt   <= '0;
    end else begin
      if (wr_valid && full && wr_stall_cnt != '1)
        wr_stall_cnt <= wr_stall_cnt + 16'd1;
      if (state == S_RD_WAIT && rd_err_pend && rd_err_cnt != '1)
        rd_err_cnt <= rd_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_oflow_mem_ctrl.sv
// Directed bench for oflow_mem_ctrl with a behavioural dual-port SRAM model.
// Stats counters are checked when OFLOW_MEM_CTRL_STATS_EN is defined.
module tb_oflow_mem_ctrl;
  localparam int DW = 284;
  localparam int AW = 8;

  logic          clk;
  logic          reset_N;
  logic          frame_start;
  logic          wr_valid;
  logic          wr_single;
  logic [DW-1:0] wr_data_0;
  logic [DW-1:0] wr_data_1;
  logic          wr_ready;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_err;
  logic [AW:0]   row_count;
`ifdef OFLOW_MEM_CTRL_STATS_EN
  logic [15:0]   wr_stall_cnt;
  logic [15:0]   rd_err_cnt;
`endif
  logic [AW-1:0] mem_address_0, mem_address_1;
  logic [DW-1:0] mem_data_in_0, mem_data_in_1;
  logic          mem_csb_0, mem_csb_1, mem_web_0, mem_web_1, mem_oeb_0, mem_oeb_1;
  logic [DW-1:0] mem_data_out_0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] d0, d1, ds;
  logic [DW-1:0] mem [256];

  oflow_mem_ctrl #(.DATA_WIDTH_MEM(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_N(reset_N), .frame_start(frame_start),
    .wr_valid(wr_valid), .wr_single(wr_single),
    .wr_data_0(wr_data_0), .wr_data_1(wr_data_1), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .row_count(row_count),
`ifdef OFLOW_MEM_CTRL_STATS_EN
    .wr_stall_cnt(wr_stall_cnt), .rd_err_cnt(rd_err_cnt),
`endif
    .mem_address_0(mem_address_0), .mem_address_1(mem_address_1),
    .mem_data_in_0(mem_data_in_0), .mem_data_in_1(mem_data_in_1),
    .mem_csb_0(mem_csb_0), .mem_csb_1(mem_csb_1),
    .mem_web_0(mem_web_0), .mem_web_1(mem_web_1),
    .mem_oeb_0(mem_oeb_0), .mem_oeb_1(mem_oeb_1),
    .mem_data_out_0(mem_data_out_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM: data appears the cycle after the address is presented.
  always @(posedge clk) begin
    if (!mem_csb_0 && !mem_web_0) mem[mem_address_0] <= mem_data_in_0;
    if (!mem_csb_0 && mem_web_0 && !mem_oeb_0) mem_data_out_0 <= mem[mem_address_0];
    if (!mem_csb_1 && !mem_web_1) mem[mem_address_1] <= mem_data_in_1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    d0 = {28'hABCDEF1, {8{32'h1234_5678}}};
    d1 = {28'h5555555, {8{32'hDEAD_BEEF}}};
    ds = {28'h0F0F0F0, {8{32'hCAFE_F00D}}};
    reset_N = 1'b0; frame_start = 1'b0; wr_valid = 1'b0; wr_single = 1'b0;
    wr_data_0 = '0; wr_data_1 = '0; rd_req = 1'b0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_csb_0", mem_csb_0, 1); check("rst_csb_1", mem_csb_1, 1);
    check("rst_web_0", mem_web_0, 1); check("rst_oeb_0", mem_oeb_0, 1);
    check("rst_addr_0", mem_address_0, 0); check("rst_din_0", mem_data_in_0, 0);
    check("rst_wr_ready", wr_ready, 0); check("rst_rd_gnt", rd_gnt, 0);
    check("rst_rd_valid", rd_valid, 0); check("rst_rd_err", rd_err, 0);
    check("rst_rd_data", rd_data, 0); check("rst_row_count", row_count, 0);
    reset_N = 1'b1;
    tick();

    // Both pending from reset: read first, then write
    wr_valid = 1'b1; wr_single = 1'b0; wr_data_0 = d0; wr_data_1 = d1;
    rd_req = 1'b1; rd_addr = 8'd0;
    #1;
    check("arb_rd_gnt_first", rd_gnt, 1); check("arb_wr_ready_first", wr_ready, 0);
    tick();
    check("arb_err_rd_no_csb", mem_csb_0, 1);
    check("arb_busy_wr_ready", wr_ready, 0); check("arb_busy_rd_gnt", rd_gnt, 0);
    tick(); tick();
    check("arb_rd_valid", rd_valid, 1); check("arb_rd_err", rd_err, 1); check("arb_rd_data", rd_data, 0);
    tick();
    check("arb_wr_ready_next", wr_ready, 1); check("arb_rd_gnt_next", rd_gnt, 0);
    tick();
    rd_req = 1'b0; wr_valid = 1'b0;
    check("arb_wr_row_count", row_count, 2); check("arb_wr_csb_0", mem_csb_0, 0);
    check("arb_wr_csb_1", mem_csb_1, 0);
    tick();

    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("fs_row_count", row_count, 0);

    // Pair write at wr_ptr 0
    wr_valid = 1'b1; wr_single = 1'b0; wr_data_0 = d0; wr_data_1 = d1;
    #1;
    check("pair_wr_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    check("pair_csb_0", mem_csb_0, 0); check("pair_csb_1", mem_csb_1, 0);
    check("pair_web_0", mem_web_0, 0); check("pair_web_1", mem_web_1, 0);
    check("pair_addr_0", mem_address_0, 0); check("pair_addr_1", mem_address_1, 1);
    check("pair_din_0", mem_data_in_0, d0); check("pair_din_1", mem_data_in_1, d1);
    check("pair_row_count", row_count, 2);
    tick();
    check("pair_idle_csb_0", mem_csb_0, 1); check("pair_idle_web_0", mem_web_0, 1);
    check("pair_idle_csb_1", mem_csb_1, 1); check("pair_hold_addr_1", mem_address_1, 1);

    // Read row 1
    rd_req = 1'b1; rd_addr = 8'd1;
    #1;
    check("rd1_gnt", rd_gnt, 1);
    tick();
    rd_req = 1'b0;
    check("rd1_csb_0", mem_csb_0, 0); check("rd1_oeb_0", mem_oeb_0, 0);
    check("rd1_web_0", mem_web_0, 1); check("rd1_addr_0", mem_address_0, 1);
    check("rd1_valid_n1", rd_valid, 0);
    tick();
    check("rd1_csb_0_n2", mem_csb_0, 1); check("rd1_valid_n2", rd_valid, 0);
    tick();
    check("rd1_valid", rd_valid, 1); check("rd1_err", rd_err, 0); check("rd1_data", rd_data, d1);
    tick();
    check("rd1_valid_drop", rd_valid, 0);

    // frame_start same cycle as wr_valid, single write
    frame_start = 1'b1; wr_valid = 1'b1; wr_single = 1'b1; wr_data_0 = ds;
    #1;
    check("fsw_wr_ready", wr_ready, 0);
    tick();
    frame_start = 1'b0;
    check("fsw_row_count", row_count, 0); check("fsw_no_csb", mem_csb_0, 1);
    #1;
    check("fsw_wr_ready_after", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    check("single_row_count", row_count, 1); check("single_csb_0", mem_csb_0, 0);
    check("single_csb_1", mem_csb_1, 1); check("single_addr_0", mem_address_0, 0);
    check("single_din_0", mem_data_in_0, ds);
    tick();

    // Read row 1 beyond row_count
    rd_req = 1'b1; rd_addr = 8'd1;
    #1;
    check("err_gnt", rd_gnt, 1);
    tick();
    rd_req = 1'b0;
    check("err_csb_n1", mem_csb_0, 1);
    tick();
    check("err_csb_n2", mem_csb_0, 1);
    tick();
    check("err_valid", rd_valid, 1); check("err_flag", rd_err, 1); check("err_data", rd_data, 0);
    tick();
`ifdef OFLOW_MEM_CTRL_STATS_EN
    check("stats_rd_err_cnt", rd_err_cnt, 1);
`endif

    // Read row 0 (single record)
    rd_req = 1'b1; rd_addr = 8'd0;
    tick();
    rd_req = 1'b0;
    tick(); tick();
    check("rd0_valid", rd_valid, 1); check("rd0_err", rd_err, 0); check("rd0_data", rd_data, ds);
    tick();

    // Fill the memory with 128 pair writes
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 128; i++) begin
      wr_valid = 1'b1; wr_single = 1'b0;
      wr_data_0 = DW'(2 * i) ^ d0;
      wr_data_1 = DW'(2 * i + 1) ^ d0;
      tick();
      wr_valid = 1'b0;
      tick();
    end
    check("full_row_count", row_count, 256);
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_single = (i % 2 == 1);
      #1;
      check("full_wr_ready", wr_ready, 0);
      tick();
      check("full_csb_0", mem_csb_0, 1); check("full_csb_1", mem_csb_1, 1);
    end
    wr_valid = 1'b0; wr_single = 1'b0;
`ifdef OFLOW_MEM_CTRL_STATS_EN
    check("stats_wr_stall_cnt", wr_stall_cnt, 5);
`endif
    rd_req = 1'b1; rd_addr = 8'd255;
    tick();
    rd_req = 1'b0;
    tick(); tick();
    check("rd255_valid", rd_valid, 1); check("rd255_err", rd_err, 0);
    check("rd255_data", rd_data, DW'(255) ^ d0);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("full_clear_row_count", row_count, 0);
`ifdef OFLOW_MEM_CTRL_STATS_EN
    check("stats_stall_clear", wr_stall_cnt, 0);
`endif

    // Reset during RD_WAIT
    wr_valid = 1'b1; wr_single = 1'b1; wr_data_0 = ds;
    tick();
    wr_valid = 1'b0;
    tick();
    rd_req = 1'b1; rd_addr = 8'd0;
    tick();
    rd_req = 1'b0;
    tick();
    reset_N = 1'b0;
    #1;
    check("rstrd_csb_0", mem_csb_0, 1); check("rstrd_oeb_0", mem_oeb_0, 1);
    check("rstrd_web_0", mem_web_0, 1); check("rstrd_row_count", row_count, 0);
    tick();
    reset_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstrd_no_valid", rd_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
